// File: rtl/mips_mdu.sv
// Multi-cycle MIPS multiply/divide unit with HI/LO: fixed-latency multiply, radix-2 restoring divide.
// Operands latched on accept; results land in HI/LO with a one-cycle done pulse.
module mips_mdu #(
   parameter int DATA_W     = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] srca,
   input  logic [DATA_W-1:0] srcb,
   input  logic              mf_req,
   input  logic              mf_sel,
   output logic [DATA_W-1:0] mf_data,
   output logic              busy,
   output logic              done,
   output logic              div0,
   output logic              stall_req
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   localparam int CNT_MAX = (MUL_CYCLES > DATA_W) ? MUL_CYCLES : DATA_W;
   localparam int CW      = $clog2(CNT_MAX);

   logic [1:0]          state;
   logic [CW-1:0]       cnt;
   logic [DATA_W-1:0]   hi, lo;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   rem, quo, dvs;
   logic                neg_q, neg_r, dz;

   logic [2*DATA_W-1:0] mul_a, mul_b;
   logic                a_neg, b_neg;
   logic [DATA_W-1:0]   a_mag, b_mag;
   logic [DATA_W:0]     shifted, diff;
   logic [DATA_W-1:0]   fix_q, fix_r;

   // op[0]=0 selects the signed variant for both MULT and DIV
   always_comb begin
      a_neg   = ~op[0] & srca[DATA_W-1];
      b_neg   = ~op[0] & srcb[DATA_W-1];
      mul_a   = {{DATA_W{a_neg}}, srca};
      mul_b   = {{DATA_W{b_neg}}, srcb};
      a_mag   = a_neg ? -srca : srca;
      b_mag   = b_neg ? -srcb : srcb;
      shifted = {rem, quo[DATA_W-1]};
      diff    = shifted - {1'b0, dvs};
      fix_q   = neg_q ? -quo : quo;
      fix_r   = neg_r ? -rem : rem;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         prod  <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         dz    <= 1'b0;
         done  <= 1'b0;
         div0  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     3'd0, 3'd1: begin
                        prod  <= mul_a * mul_b;
                        cnt   <= CW'(MUL_CYCLES - 1);
                        div0  <= 1'b0;
                        state <= S_MUL;
                     end
                     3'd2, 3'd3: begin
                        div0  <= 1'b0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dvs   <= b_mag;
                        rem   <= '0;
                        cnt   <= CW'(DATA_W - 1);
                        // divide-by-zero keeps the raw dividend for HI and skips iteration
                        if (srcb == '0) begin
                           dz    <= 1'b1;
                           quo   <= srca;
                           state <= S_FIX;
                        end else begin
                           dz    <= 1'b0;
                           quo   <= a_mag;
                           state <= S_DIV;
                        end
                     end
                     3'd4:    hi <= srca;
                     3'd5:    lo <= srca;
                     default: ;
                  endcase
               end
            end
            S_MUL: begin
               if (cnt == '0) begin
                  {hi, lo} <= prod;
                  done     <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_DIV: begin
               if (!diff[DATA_W]) begin
                  rem <= diff[DATA_W-1:0];
                  quo <= {quo[DATA_W-2:0], 1'b1};
               end else begin
                  rem <= shifted[DATA_W-1:0];
                  quo <= {quo[DATA_W-2:0], 1'b0};
               end
               if (cnt == '0) state <= S_FIX;
               else           cnt   <= cnt - CW'(1);
            end
            default: begin
               if (dz) begin
                  lo   <= '1;
                  hi   <= quo;
                  div0 <= 1'b1;
               end else begin
                  lo <= fix_q;
                  hi <= fix_r;
               end
               done  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state != S_IDLE);
   assign stall_req = busy & (start | mf_req);
   assign mf_data   = mf_sel ? hi : lo;

endmodule
